// File: rtl/siso_shift_reg.sv
// Serial-in serial-out shift register: DEPTH-stage bit delay line with complementary output.
// Optional feature macro: SISO_TAPS_EN exposes every stage on q_taps.
module siso_shift_reg #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             qout,
    output logic             qoutb
`ifdef SISO_TAPS_EN
    ,
    output logic [DEPTH-1:0] q_taps
`endif
);

    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
        $error("siso_shift_reg: DEPTH must be in 1..64");
    end

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    // Loop form keeps DEPTH==1 legal, where a {stage_q[DEPTH-2:0], din} slice would not be.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign qout  = stage_q[DEPTH-1];
    assign qoutb = ~stage_q[DEPTH-1];

`ifdef SISO_TAPS_EN
    assign q_taps = stage_q;
`endif

endmodule

// File: tb/tb_siso_shift_reg.sv
// Self-checking bench for siso_shift_reg: DEPTH=4 and DEPTH=1 instances share clk/rst/din.
// A queue-based history model is compared every cycle; directed literals pin the model.
module tb_siso_shift_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic qout4, qoutb4, qout1, qoutb1;
`ifdef SISO_TAPS_EN
    logic [3:0] taps4;
    logic [0:0] taps1;
`endif

    always #5 clk = ~clk;

    siso_shift_reg #(.DEPTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .qout  (qout4),
        .qoutb (qoutb4)
`ifdef SISO_TAPS_EN
        ,
        .q_taps(taps4)
`endif
    );

    siso_shift_reg #(.DEPTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .qout  (qout1),
        .qoutb (qoutb1)
`ifdef SISO_TAPS_EN
        ,
        .q_taps(taps1)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: history of bits accepted since the last reset edge, newest first.
    bit          hist[$];
    int unsigned since_rst   = 0;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            hist.delete();
            since_rst   = 0;
            model_valid = 1'b1;
        end else begin
            hist.push_front(din);
            if (hist.size() > 64) void'(hist.pop_back());
            since_rst++;
        end
    end

    // Bit sitting in stage i: the (i+1)-th most recent accepted bit, or 0 if not yet that many.
    function automatic logic model_stage(input int unsigned i);
        return (since_rst > i) ? logic'(hist[i]) : 1'b0;
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_qout4",  qout4,  model_stage(3));
            check("cmp_qoutb4", qoutb4, ~model_stage(3));
            check("cmp_qout1",  qout1,  model_stage(0));
            check("cmp_qoutb1", qoutb1, ~model_stage(0));
`ifdef SISO_TAPS_EN
            for (int i = 0; i < 4; i++)
                check($sformatf("cmp_taps4[%0d]", i), taps4[i], model_stage(i));
            check("cmp_taps1", taps1[0], model_stage(0));
`endif
        end
    end

    task automatic step(input logic r, input logic d);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    logic exp_pulse[6];
    logic pat[6];

    initial begin
        // 1: reset held with din=1
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            check("rst_qout",  qout4,  1'b0);
            check("rst_qoutb", qoutb4, 1'b1);
        end

        // 2: single pulse emerges after the 4th edge only
        exp_pulse = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            step(1'b1, (k == 0) ? 1'b1 : 1'b0);
            check($sformatf("pulse_qout_e%0d", k + 1), qout4, exp_pulse[k]);
            check($sformatf("pulse_qoutb_e%0d", k + 1), qoutb4, ~exp_pulse[k]);
        end

        // 3: pattern 1,0,0,1,1,0 reappears 4 edges later
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            step(1'b1, (k < 6) ? pat[k] : 1'b0);
            if (k >= 3) check($sformatf("pat_qout_e%0d", k + 1), qout4, pat[k-3]);
        end

        // 4: mid-stream reset discards buffered ones
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("midrst_qout", qout4, 1'b0);
`ifdef SISO_TAPS_EN
        check("midrst_taps_zero", logic'(taps4 == 4'b0000), 1'b1);
`endif
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("midrst_after_e%0d", k + 1), qout4, 1'b0);
        end
        step(1'b1, 1'b1);
        check("midrst_first_bit_arrives", qout4, 1'b1);

        // 5: DEPTH=1 follows din with one edge of delay
        for (int k = 0; k < 8; k++) begin
            step(1'b1, logic'(k % 2));
            check($sformatf("d1_qout_e%0d", k + 1), qout1, logic'(k % 2));
            check($sformatf("d1_qoutb_e%0d", k + 1), qoutb1, ~logic'(k % 2));
        end

`ifdef SISO_TAPS_EN
        // 6: shift 1,1,0,1 (oldest first) -> stage3..stage0 = 1,1,0,1
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("taps_1101", logic'(taps4 == 4'b1101), 1'b1);
        if (taps4 != 4'b1101) $display("FAIL taps_value: got %b, expected 1101", taps4);
`endif

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
